// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing for the 1RW+1R OpenRAM front-end controller.
package sram_ctrl_pkg;

    localparam int DATA_W    = 2;
    localparam int ADDR_W    = 4;
    localparam int RAM_DEP   = 1 << ADDR_W;
    localparam int RSP_DEP   = 2;
    // Two in-flight read stages plus the buffer occupancy must fit.
    localparam int CREDIT_W  = $clog2(RSP_DEP + 3);
    localparam int RSP_CNT_W = $clog2(RSP_DEP + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
    } rd_stage_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding captured read data until the consumer takes it.
module sram_rsp_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot a full-buffer push lands in.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk0) begin
        if (rst0) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge clk0) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// Front-end for a 1RW+1R SRAM macro: zero-fill after reset, then valid/ready writes on port 0
// and credit-limited reads on port 1 with a buffered, in-order response stream.
module sram_1rw1r_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RSP_DEPTH  = RSP_DEP
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam int CRD_W = credit_width(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    rd_stage_t             rd_s1;
    logic                  rd_s2_vld;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  rd_collide;
    logic                  rsp_pop;
    logic                  rsp_full;
    logic                  rsp_empty;
    logic [CNT_W-1:0]      rsp_count;
    logic [CRD_W-1:0]      outstanding;
    logic                  unused_dout0;

    assign unused_dout0 = ^dout0;

    always_ff @(posedge clk0) begin
        if (rst0) state <= INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path through this block infers a latch.
        state_nxt = state;
        if (state == INIT && cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) state_nxt = RUN;
    end

    // Same-address read is held off one cycle so it sees the write instead of racing it.
    assign rd_collide  = wr_valid && rd_valid && (wr_addr == rd_addr);
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign outstanding = CRD_W'(rd_s1.vld) + CRD_W'(rd_s2_vld) + CRD_W'(rsp_count);
    assign rd_ready    = (state == RUN) && !rd_collide &&
                         ((outstanding - CRD_W'(rsp_pop)) < CRD_W'(RSP_DEPTH));
    assign wr_accept   = wr_valid && wr_ready;
    assign rd_accept   = rd_valid && rd_ready;
    assign addr1       = rd_s1.addr;
    assign rsp_valid   = !rsp_empty;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            csb0      <= 1'b1;
            web0      <= 1'b1;
            addr0     <= '0;
            din0      <= '0;
            cnt       <= '0;
            csb1      <= 1'b1;
            rd_s1     <= '0;
            rd_s2_vld <= 1'b0;
            wr_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            wr_ready  <= (state_nxt == RUN);
            init_done <= (state_nxt == RUN);
            csb1      <= ~rd_accept;
            rd_s1.vld <= rd_accept;
            if (rd_accept) rd_s1.addr <= rd_addr;
            rd_s2_vld <= rd_s1.vld;
            if (state == INIT) begin
                csb0  <= 1'b0;
                web0  <= 1'b0;
                addr0 <= cnt;
                din0  <= '0;
                cnt   <= cnt + 1'b1;
            end else begin
                csb0 <= ~wr_accept;
                web0 <= ~wr_accept;
                if (wr_accept) begin
                    addr0 <= wr_addr;
                    din0  <= wr_data;
                end
            end
        end
    end

    // dout1 is valid two edges after acceptance; capture straight into the buffer.
    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk0      (clk0),
        .rst0      (rst0),
        .push      (rd_s2_vld),
        .push_data (dout1),
        .pop       (rsp_pop),
        .pop_data  (rsp_data),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            assert (!(rd_s2_vld && rsp_full && !rsp_pop))
                else $error("sram_1rw1r_ctrl: read capture into a full response buffer");
        end
    end

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Directed and scoreboarded stimulus for sram_1rw1r_ctrl driving a behavioural 1RW+1R macro.
module tb_sram_1rw1r_ctrl;

    localparam int DW    = 2;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1 = '0;

    always #5 clk0 = ~clk0;

    sram_1rw1r_ctrl dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1)
    );

    // Macro: pins sampled at posedge, array written and read at the following negedge.
    logic [DW-1:0] macro_mem [DEPTH] = '{default: 2'b11};
    logic          m_csb0  = 1'b1;
    logic          m_web0  = 1'b1;
    logic          m_csb1  = 1'b1;
    logic [AW-1:0] m_addr0 = '0;
    logic [AW-1:0] m_addr1 = '0;
    logic [DW-1:0] m_din0  = '0;

    assign dout0 = '0;

    always @(posedge clk0) begin
        m_csb0  <= csb0;
        m_web0  <= web0;
        m_addr0 <= addr0;
        m_din0  <= din0;
        m_csb1  <= csb1;
        m_addr1 <= addr1;
    end

    always @(negedge clk0) begin
        if (!m_csb0 && !m_web0) macro_mem[m_addr0] <= m_din0;
        if (!m_csb1)            dout1 <= macro_mem[m_addr1];
    end

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad   = 0;
    bit            last_wr_hs;
    bit            last_rd_hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Records this cycle's handshakes into the model, then advances to just after the next negedge.
    task automatic tick();
        #1;
        last_wr_hs = wr_valid && wr_ready;
        last_rd_hs = rd_valid && rd_ready;
        if (rsp_valid && rsp_ready) begin
            check("rsp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rsp_data", rsp_data, exp_q.pop_front());
        end
        if (last_rd_hs) exp_q.push_back(ref_mem[rd_addr]);
        if (last_wr_hs) ref_mem[wr_addr] = wr_data;
        @(negedge clk0);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_csb0"},      csb0,      1);
        check({tag, "_web0"},      web0,      1);
        check({tag, "_csb1"},      csb1,      1);
        check({tag, "_addr0"},     addr0,     0);
        check({tag, "_addr1"},     addr1,     0);
        check({tag, "_din0"},      din0,      0);
        check({tag, "_wr_ready"},  wr_ready,  0);
        check({tag, "_rd_ready"},  rd_ready,  0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_init_done"}, init_done, 0);
    endtask

    task automatic watch_init(input string tag);
        int n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!csb0 && !web0) begin
                check({tag, "_addr"}, addr0, n);
                check({tag, "_din"},  din0,  0);
                if (n == 8) begin
                    check({tag, "_wr_ready_low"}, wr_ready, 0);
                    check({tag, "_rd_ready_low"}, rd_ready, 0);
                end
                if (n == 14) check({tag, "_done_early"}, init_done, 0);
                if (n == 15) check({tag, "_done_last"},  init_done, 1);
                n++;
            end
        end
        check({tag, "_writes"}, n, 16);
        check({tag, "_done"},   init_done, 1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int c = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        do begin tick(); c++; end while (!last_wr_hs && c < 20);
        check("wr_accept", last_wr_hs, 1);
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int c = 0;
        rd_valid = 1'b1;
        rd_addr  = a;
        do begin tick(); c++; end while (!last_rd_hs && c < 20);
        check("rd_accept", last_rd_hs, 1);
        rd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle"},    rsp_valid,    0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_acc;
        int cyc;
        // NOTE: stimulus uses blocking assignments, applied away from the active edge.
        rst0      = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk0);
        #1;
        check_reset("rst");

        // Zero-fill, then every word reads back as zero.
        rst0 = 1'b0;
        watch_init("init");
        rsp_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) do_read(AW'(a));
        drain("zero");

        // Write then read: response two edges after acceptance.
        do_write(4'd5, 2'b10);
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 4'd5;
        tick();
        check("lat_rd_acc", last_rd_hs, 1);
        rd_valid = 1'b0;
        check("lat_k0_valid", rsp_valid, 0);
        tick();
        check("lat_k1_valid", rsp_valid, 0);
        tick();
        check("lat_k2_valid", rsp_valid, 1);
        check("lat_k2_data",  rsp_data,  2'b10);
        drain("lat");

        // Same-address collision: write wins, read follows next cycle with new data.
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_data  = 2'b11;
        rd_valid = 1'b1;
        rd_addr  = 4'd3;
        #1;
        check("coll_rd_ready", rd_ready, 0);
        check("coll_wr_ready", wr_ready, 1);
        tick();
        check("coll_wr_hs", last_wr_hs, 1);
        check("coll_rd_hs", last_rd_hs, 0);
        wr_valid = 1'b0;
        tick();
        check("coll_rd_next", last_rd_hs, 1);
        rd_valid = 1'b0;
        drain("coll");

        // Backpressure: only two reads fit while responses are held.
        do_write(4'd0, 2'b01);
        do_write(4'd1, 2'b10);
        do_write(4'd2, 2'b00);
        rsp_ready = 1'b0;
        n_acc     = 0;
        rd_valid  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rd_addr = AW'(n_acc);
            tick();
            if (last_rd_hs) n_acc++;
        end
        check("bp_accepted", n_acc, 2);
        check("bp_rd_ready", rd_ready, 0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && n_acc < 4; c++) begin
            rd_addr = AW'(n_acc);
            tick();
            if (last_rd_hs) n_acc++;
        end
        rd_valid = 1'b0;
        check("bp_all_accepted", n_acc, 4);
        drain("bp");

        // Reset with buffered responses, then reset again partway through the clear.
        rsp_ready = 1'b0;
        do_read(4'd1);
        do_read(4'd2);
        tick();
        tick();
        check("pre_rst_valid", rsp_valid, 1);
        rst0 = 1'b1;
        tick();
        exp_q.delete();
        check_reset("rst_run");
        rst0 = 1'b0;
        cyc  = 0;
        do begin tick(); cyc++; end while (!(!csb0 && addr0 == 4'd6) && cyc < 20);
        check("mid_init_reached", 32'(!csb0 && addr0 == 4'd6), 1);
        rst0 = 1'b1;
        tick();
        check_reset("rst_init");
        rst0 = 1'b0;
        watch_init("reinit");
        rsp_ready = 1'b1;
        do_read(4'd1);
        do_read(4'd3);
        drain("reinit_rd");

        // Random mixed traffic against the scoreboard.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 500 && cyc < 5000) begin
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_data   = DW'($urandom_range(0, 3));
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_acc += int'(last_wr_hs) + int'(last_rd_hs);
            cyc++;
        end
        check("rand_count", 32'(n_acc >= 500), 1);
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
